mem_access_unit: RTL

//  Initiator side of the data_memory port: the load/store unit between the MEM

---
 rtl/mem_access_pkg.sv | 68 ++++++
 rtl/mem_lane_align.sv | 27 ++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Shared size codes, FSM state encoding and byte-lane
//                extract/merge helpers for the load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Access size codes carried on req_size
    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    // Controller states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Right-justified mask covering the bytes of one access
    function automatic logic [31:0] sizeMask(input logic [1:0] size);
        case (size)
            SZ_BYTE: sizeMask = 32'h0000_00FF;
            SZ_HALF: sizeMask = 32'h0000_FFFF;
            default: sizeMask = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Pull the addressed lanes down to bit 0 and sign/zero-extend them.
    // A word access has an all-ones mask, so the extension term vanishes.
    function automatic logic [31:0] laneExtract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  offset,
        input logic        isSigned
    );
        logic [31:0] shifted;
        logic [31:0] mask;
        logic        signBit;
        shifted = word >> {offset, 3'b000};
        mask    = sizeMask(size);
        case (size)
            SZ_BYTE: signBit = shifted[7];
            SZ_HALF: signBit = shifted[15];
            default: signBit = 1'b0;
        endcase
        laneExtract = (shifted & mask) | ({32{isSigned & signBit}} & ~mask);
    endfunction

    // Replace only the addressed lanes of oldWord; data bits above the
    // access size are masked away.
    function automatic logic [31:0] laneMerge(
        input logic [31:0] oldWord,
        input logic [31:0] newData,
        input logic [1:0]  size,
        input logic [1:0]  offset
    );
        logic [31:0] mask;
        mask      = sizeMask(size) << {offset, 3'b000};
        laneMerge = (oldWord & ~mask) | ((newData << {offset, 3'b000}) & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational byte-lane alignment: load extraction with
//                sign/zero extension, and store merge into an old word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] readWord,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        isSigned,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic [31:0] mergedWord
);

    // Load path: addressed lanes, right-justified and extended
    assign loadData   = laneExtract(readWord, size, offset, isSigned);

    // Store path: new lanes dropped into the word just read
    assign mergedWord = laneMerge(readWord, storeData, size, offset);

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store unit driving a word-wide data memory. Handles
//                byte/half/word accesses, read-modify-write for sub-word
//                stores, and alignment/size/range checking at accept time.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int AW          = 32
) (
    input  logic          clock_in,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_address,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_error,
    output logic [AW-1:0] mem_address,
    output logic [31:0]   mem_write_data,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [31:0]   mem_read_data
);

    // First illegal byte address, one bit wider so it cannot overflow
    localparam logic [AW:0] c_byteLimit = (AW+1)'(DEPTH_WORDS * 4);

    state_t        r_state;
    logic [1:0]    r_size;
    logic [1:0]    r_offset;
    logic          r_signed;
    logic          r_write;
    logic [31:0]   r_wdata;

    logic          w_accept;
    logic          w_sizeError;
    logic          w_alignError;
    logic          w_rangeError;
    logic          w_reqError;
    logic          w_wordStore;
    logic [AW-1:0] w_wordIndex;
    logic [31:0]   w_loadData;
    logic [31:0]   w_mergedWord;

    // Request decode and checks, evaluated on the incoming request
    assign w_accept     = req_valid & req_ready;
    assign w_sizeError  = (req_size == SZ_ILLEGAL);
    assign w_alignError = ((req_size == SZ_HALF) && req_address[0]) ||
                          ((req_size == SZ_WORD) && (req_address[1:0] != 2'b00));
    assign w_rangeError = ({1'b0, req_address} >= c_byteLimit);
    assign w_reqError   = w_sizeError | w_alignError | w_rangeError;
    assign w_wordStore  = req_write && (req_size == SZ_WORD);
    assign w_wordIndex  = {2'b00, req_address[AW-1:2]};

    // Lane alignment works on the live memory word during the READ cycle
    mem_lane_align u_laneAlign (
        .readWord   (mem_read_data),
        .size       (r_size),
        .offset     (r_offset),
        .isSigned   (r_signed),
        .storeData  (r_wdata),
        .loadData   (w_loadData),
        .mergedWord (w_mergedWord)
    );

    // Controller FSM with registered strobes, handshake and response
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_size         <= SZ_BYTE;
            r_offset       <= 2'b00;
            r_signed       <= 1'b0;
            r_write        <= 1'b0;
            r_wdata        <= 32'h0;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'h0;
            resp_error     <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= 32'h0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
        end else begin
            // Strobes and the response pulse last exactly one cycle
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        req_ready <= 1'b0;
                        r_size    <= req_size;
                        r_offset  <= req_address[1:0];
                        r_signed  <= req_signed;
                        r_write   <= req_write;
                        r_wdata   <= req_wdata;
                        if (w_reqError) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0;
                            r_state    <= ST_DONE;
                        end else if (w_wordStore) begin
                            mem_address    <= w_wordIndex;
                            mem_write_data <= req_wdata;
                            mem_write      <= 1'b1;
                            r_state        <= ST_WRITE;
                        end else begin
                            mem_address <= w_wordIndex;
                            mem_read    <= 1'b1;
                            r_state     <= ST_READ;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (r_write) begin
                        // Sub-word store: write back the merged word
                        mem_write_data <= w_mergedWord;
                        mem_write      <= 1'b1;
                        r_state        <= ST_WRITE;
                    end else begin
                        resp_rdata <= w_loadData;
                        resp_error <= 1'b0;
                        resp_valid <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    resp_rdata <= 32'h0;
                    resp_error <= 1'b0;
                    resp_valid <= 1'b1;
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
